mult64_seq_arbiter: RTL and testbench

MULT64_SEQ_ARBITER -- requirements
Module: mult64_seq_arbiter

---
 rtl/mult64_seq_arbiter.sv | 106 ++++++++++
 tb/tb_mult64_seq_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mult64_seq_arbiter.sv
// Two-requester round-robin front end feeding a radix-2^RADIX_BITS sequential 64x64->128 multiplier.
// Optional macro MULT64_EARLY_TERM_EN finishes RUN as soon as the remaining multiplier bits are zero.
module mult64_seq_arbiter #(
  parameter int RADIX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [63:0]  req0_a,
  input  logic [63:0]  req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [63:0]  req1_a,
  input  logic [63:0]  req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [127:0] res_product,
  output logic         busy
);
  localparam int STEPS = 64 / RADIX_BITS;
  localparam int SW    = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic [63:0]  a_sh, b_q, a_next;
  logic [127:0] acc, pp, acc_next;
  logic [SW-1:0] step;
  logic [6:0]   shamt;
  logic         id_q, last_grant;
  logic         grant0, grant1, last_step, fin;

  // Tie goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;

  // One radix digit of A times all of B, placed at the digit's weight.
  assign pp        = {64'b0, b_q} * {{(128-RADIX_BITS){1'b0}}, a_sh[RADIX_BITS-1:0]};
  assign shamt     = 7'(step) * 7'(RADIX_BITS);
  assign acc_next  = acc + (pp << shamt);
  assign a_next    = a_sh >> RADIX_BITS;
  assign last_step = (step == SW'(STEPS-1));

`ifdef MULT64_EARLY_TERM_EN
  assign fin = last_step || (a_next == 64'b0);
`else
  assign fin = last_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      res_product <= '0;
      res_id      <= 1'b0;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      a_sh        <= '0;
      b_q         <= '0;
      acc         <= '0;
      step        <= '0;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          a_sh       <= req1_ready ? req1_a : req0_a;
          b_q        <= req1_ready ? req1_b : req0_b;
          id_q       <= req1_ready;
          last_grant <= req1_ready;
          acc        <= '0;
          step       <= '0;
          busy       <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          acc  <= acc_next;
          a_sh <= a_next;
          step <= step + 1'b1;
          if (fin) begin
            res_valid   <= 1'b1;
            res_product <= acc_next;
            res_id      <= id_q;
            state       <= DONE;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult64_seq_arbiter.sv
// Directed bench for mult64_seq_arbiter: arbitration, latency, back-pressure, reset abort.
module tb_mult64_seq_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0]  req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_id, busy;
  logic [127:0] res_product;

  int errors = 0;
  int checks = 0;

  mult64_seq_arbiter #(.RADIX_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_product(res_product), .busy(busy)
  );

  always #5 clk = ~clk;

  // Present one request, wait for acceptance, then count cycles until res_valid.
  task automatic do_op(input logic sel, input logic [63:0] a, input logic [63:0] b,
                       output int lat);
    int n;
    @(negedge clk);
    if (sel) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(sel ? req1_ready : req0_ready) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL accept_timeout: got no ready, expected ready");
    end
    @(posedge clk); #1;
    if (sel) req1_valid = 1'b0; else req0_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!res_valid) lat = 0;
    // lat is the edge count from the accept edge to res_valid high
    lat = res_valid ? lat - 1 : -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (res_product !== 128'd0) begin errors++; $display("FAIL rst_product: got %0h expected 0", res_product); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL rst_id: got %b expected 0", res_id); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, exp_lat;
`ifdef MULT64_EARLY_TERM_EN
    exp_lat = 1;
`else
    exp_lat = 16;
`endif
    res_ready = 1'b1;
    do_op(1'b0, 64'd3, 64'd5, lat);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (res_product !== 128'd15) begin errors++; $display("FAIL basic_product: got %0h expected f", res_product); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL basic_id: got %b expected 0", res_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done: got %b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_release: got valid=%b busy=%b expected 0 0", res_valid, busy);
    end
  endtask

  task automatic test_max;
    int lat;
    res_ready = 1'b1;
    do_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    checks++; if (res_product !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++; $display("FAIL max_product: got %0h expected fffffffffffffffe0000000000000001", res_product);
    end
    checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL max_id: got %b expected 1", res_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin;
    int n;
    test_reset();
    res_ready = 1'b1;
    req0_a = 64'd2; req0_b = 64'd2; req1_a = 64'd3; req1_b = 64'd3;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rr_first_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1; req0_valid = 1'b0;
    n = 0; while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (res_valid !== 1'b1 || res_product !== 128'd4 || res_id !== 1'b0) begin
      errors++; $display("FAIL rr_first_result: got v=%b p=%0h id=%b expected 1 4 0", res_valid, res_product, res_id);
    end
    // No accept on the handshake edge; req1 wins on the following IDLE cycle.
    @(posedge clk); #1;
    checks++; if (req1_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL rr_second_grant: got r1=%b v=%b expected 1 0", req1_ready, res_valid);
    end
    @(posedge clk); #1; req1_valid = 1'b0;
    n = 0; while (!res_valid && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (res_valid !== 1'b1 || res_product !== 128'd9 || res_id !== 1'b1) begin
      errors++; $display("FAIL rr_second_result: got v=%b p=%0h id=%b expected 1 9 1", res_valid, res_product, res_id);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rr_third_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_hold;
    int lat;
    res_ready = 1'b0;
    do_op(1'b1, 64'h1_2345_6789, 64'h1000, lat);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 64'd9; req0_b = 64'd9; req1_a = 64'd8; req1_b = 64'd8;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_product !== 128'h1234_5678_9000 || res_id !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b p=%0h id=%b r0=%b r1=%b expected 1 123456789000 1 0 0",
                 i, res_valid, res_product, res_id, req0_ready, req1_ready);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release: got v=%b busy=%b expected 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, seen;
    res_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd11;
    @(posedge clk); #1; req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got v=%b busy=%b expected 0 0", res_valid, busy);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (res_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrun_no_result: got %0d valid cycles expected 0", seen); end
    do_op(1'b0, 64'd7, 64'd6, lat);
    checks++; if (res_product !== 128'd42 || res_id !== 1'b0) begin
      errors++; $display("FAIL midrun_after: got p=%0h id=%b expected 2a 0", res_product, res_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_early_term;
    int lat, exp_lat;
`ifdef MULT64_EARLY_TERM_EN
    exp_lat = 1;
`else
    exp_lat = 16;
`endif
    res_ready = 1'b1;
    do_op(1'b0, 64'd1, 64'd7, lat);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL early_latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (res_product !== 128'd7) begin errors++; $display("FAIL early_product: got %0h expected 7", res_product); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_basic();
    test_max();
    test_round_robin();
    test_hold();
    test_reset_mid_run();
    test_early_term();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
